// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// signs handled by operating on magnitudes and fixing up in a final cycle.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] quo_out,
   output logic [WIDTH-1:0] rem_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] b_mag;
   logic             a_neg;
   logic             q_neg;
   logic             zero_div;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;

   // The partial remainder never reaches 2*divisor, so WIDTH+1 bits hold the
   // shifted remainder and the sign of the trial subtract without overflow.
   always_comb begin
      a_abs   = (sign_in && a_in[WIDTH-1]) ? -a_in : a_in;
      b_abs   = (sign_in && b_in[WIDTH-1]) ? -b_in : b_in;
      r_shift = {r_reg, q_reg[WIDTH-1]};
      trial   = r_shift - {1'b0, b_mag};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         q_reg    <= '0;
         r_reg    <= '0;
         b_mag    <= '0;
         a_neg    <= 1'b0;
         q_neg    <= 1'b0;
         zero_div <= 1'b0;
         count    <= '0;
         quo_out  <= '0;
         rem_out  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  a_neg <= sign_in & a_in[WIDTH-1];
                  q_neg <= sign_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                  b_mag <= b_abs;
                  count <= '0;
                  r_reg <= '0;
                  // On a zero divisor q_reg keeps the raw dividend for HI.
                  if (b_in == '0) begin
                     zero_div <= 1'b1;
                     q_reg    <= a_in;
                     state    <= FIX;
                  end else begin
                     zero_div <= 1'b0;
                     q_reg    <= a_abs;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               if (trial[WIDTH]) begin
                  r_reg <= r_shift[WIDTH-1:0];
                  q_reg <= {q_reg[WIDTH-2:0], 1'b0};
               end else begin
                  r_reg <= trial[WIDTH-1:0];
                  q_reg <= {q_reg[WIDTH-2:0], 1'b1};
               end
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               if (zero_div) begin
                  quo_out  <= '1;
                  rem_out  <= q_reg;
                  div_zero <= 1'b1;
               end else begin
                  quo_out  <= q_neg ? -q_reg : q_reg;
                  rem_out  <= a_neg ? -r_reg : r_reg;
                  div_zero <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
